// File: rtl/m6809_clkrst_gen_if.sv
// E/Q clock and reset bundle between the generator and the 6809 card.
interface m6809_clkrst_gen_if;
   logic RSTSW_B;
   logic MRDY;
   logic ECLK;
   logic QCLK;
   logic RESET_B;
   logic ECYC;
   logic STRETCH;

   modport master (
      input  RSTSW_B,
      input  MRDY,
      output ECLK,
      output QCLK,
      output RESET_B,
      output ECYC,
      output STRETCH
   );

   modport slave (
      output RSTSW_B,
      output MRDY,
      input  ECLK,
      input  QCLK,
      input  RESET_B,
      input  ECYC,
      input  STRETCH
   );
endinterface

// File: rtl/m6809_clkrst_gen.sv
// 6809 E/Q quadrature clock and power-on/button reset generator.
// Define MRDY_STRETCH_EN to enable MRDY-driven E-high stretching.
module m6809_clkrst_gen #(
   parameter int QDIV          = 4,
   parameter int RESET_ECYCLES = 16,
   parameter int MAX_STRETCH   = 8
) (
   input logic                CLK,
   input logic                RST,
   m6809_clkrst_gen_if.master bus
);
   localparam int QW = $clog2(QDIV);
   localparam int HW = $clog2(RESET_ECYCLES + 1);
   localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
   localparam logic [HW-1:0] HLAST = HW'(RESET_ECYCLES - 1);
   localparam logic [HW-1:0] HMAX  = HW'(RESET_ECYCLES);
   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH3 = 2'd3;

   logic [QW-1:0] qcnt, qcnt_nxt;
   logic [1:0]    ph, ph_nxt;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic          hold, ecyc_nxt, rstb_nxt;
   logic          sync1, sw_b;
   logic          eclk, qclk, ecyc, reset_b;

`ifdef MRDY_STRETCH_EN
   localparam int SW = $clog2(MAX_STRETCH + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_STRETCH);

   logic [SW-1:0] scnt;
   logic          stretch;

   // Parking in ph3 for another quarter keeps E high and Q low.
   assign hold = !bus.MRDY && (scnt != SMAX);

   always_ff @(posedge CLK) begin
      if (RST) begin
         scnt    <= '0;
         stretch <= 1'b0;
      end else if (qcnt == QLAST && ph == PH3) begin
         if (hold) begin
            scnt    <= scnt + SW'(1);
            stretch <= 1'b1;
         end else begin
            scnt    <= '0;
            stretch <= 1'b0;
         end
      end
   end

   assign bus.STRETCH = stretch;
`else
   assign hold        = 1'b0;
   assign bus.STRETCH = 1'b0;
`endif

   always_comb begin
      qcnt_nxt = qcnt + QW'(1);
      ph_nxt   = ph;
      ecyc_nxt = 1'b0;
      if (qcnt == QLAST) begin
         qcnt_nxt = '0;
         if (ph != PH3) begin
            ph_nxt = ph + 2'd1;
         end else if (!hold) begin
            ph_nxt   = PH0;
            ecyc_nxt = 1'b1;
         end
      end
   end

   // Button low always wins over a completing hold count.
   always_comb begin
      hcnt_nxt = hcnt;
      rstb_nxt = reset_b;
      if (!sw_b) begin
         hcnt_nxt = '0;
         rstb_nxt = 1'b0;
      end else if (ecyc_nxt && hcnt != HMAX) begin
         hcnt_nxt = hcnt + HW'(1);
         if (hcnt == HLAST) begin
            rstb_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         qcnt    <= '0;
         ph      <= PH0;
         eclk    <= 1'b0;
         qclk    <= 1'b0;
         ecyc    <= 1'b0;
         reset_b <= 1'b0;
         hcnt    <= '0;
         sync1   <= 1'b1;
         sw_b    <= 1'b1;
      end else begin
         qcnt    <= qcnt_nxt;
         ph      <= ph_nxt;
         eclk    <= ph_nxt[1];
         qclk    <= ^ph_nxt;
         ecyc    <= ecyc_nxt;
         reset_b <= rstb_nxt;
         hcnt    <= hcnt_nxt;
         sync1   <= bus.RSTSW_B;
         sw_b    <= sync1;
      end
   end

   assign bus.ECLK    = eclk;
   assign bus.QCLK    = qclk;
   assign bus.ECYC    = ecyc;
   assign bus.RESET_B = reset_b;
endmodule
